sim_status: RTL and testbench
=============================

SIM_STATUS -- requirements
Module: sim_status

Interface
REQ-001 SHALL have parameter ERR_MAX, default 8: error count (1..255) that ends the test as FAIL.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 16: cycles (1..65535) between verdict and finish request.
REQ-003 SHALL have parameter WDOG_CYCLES, default 1024: idle cycles (1..2^32-1) without heartbeat before watchdog verdict.
REQ-004 SHALL have port sim_status_clk_ip  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port sim_status_rst_n_ip  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sim_status_pass_ip  input  1  test-pass event, one-cycle pulse.
REQ-007 SHALL have port sim_status_err_ip  input  1  error event, counted once per high cycle.
REQ-008 SHALL have port sim_status_beat_ip  input  1  DUV activity heartbeat.
REQ-009 SHALL have port sim_status_finish_ack_ip  input  1  finish acknowledge from the simulation controller.
REQ-010 SHALL have port sim_status_finish_req_op  output  1  finish request to the simulation controller.
REQ-011 SHALL have port sim_status_code_op  output  2  verdict: 00 running, 01 pass, 10 fail, 11 watchdog.
REQ-012 SHALL have port sim_status_err_cnt_op  output  8  errors seen, saturating.
REQ-013 SHALL have port sim_status_cycles_op  output  32  cycles since reset release, saturating.
REQ-014 SHALL have port sim_status_done_op  output  1  handshake complete, terminal.

Function
REQ-015 SHALL implement states RUN, DRAIN, REQ, DONE; reset enters RUN.
REQ-016 RUN: err_cnt reaching ERR_MAX SHALL set code 10, go DRAIN next cycle.
REQ-017 RUN: pass pulse SHALL set code 01 if err_cnt==0 after this cycle's count, else 10, and go DRAIN.
REQ-018 RUN: watchdog expiry SHALL set code 11, go DRAIN.
REQ-019 Same-cycle verdict priority SHALL be fail > pass > watchdog; err and pass together yield 10.
REQ-020 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then enter REQ.
REQ-021 Errors SHALL be counted in RUN and DRAIN; an error in DRAIN SHALL demote code 01 to 10; 11 is never changed.
REQ-022 Errors in REQ and DONE SHALL be ignored.
REQ-023 err_cnt SHALL saturate at 255, never wrap.
REQ-024 cycles SHALL increment every cycle in RUN and DRAIN, freeze in REQ/DONE, saturate at 0xFFFFFFFF.
REQ-025 finish_req SHALL be registered, high on REQ entry, held high until ack is sampled high.
REQ-026 Ack sampled high in REQ SHALL enter DONE; finish_req low and done high on the next cycle.
REQ-027 Ack outside REQ SHALL be ignored; ack already high on REQ entry SHALL complete one cycle later.
REQ-028 DONE SHALL be terminal until reset; pass, err, beat and ack have no effect.
REQ-029 Pass pulses after the first verdict SHALL be ignored.
REQ-030 Outputs SHALL be driven from flops only, no combinational input-to-output path.

Reset
REQ-031 Low reset at a rising edge SHALL force RUN, code 00, err_cnt 0, cycles 0, finish_req 0, done 0, watchdog and drain counters 0.
REQ-032 Reset SHALL take priority over every event in the same cycle, including mid-DRAIN and mid-handshake.
REQ-033 First count SHALL occur on the first edge with reset high; cycles reads 1 after that edge.

Configuration
REQ-034 Macro EXM_SIM_STATUS_WATCHDOG_EN SHALL gate the watchdog.
REQ-035 Defined: idle counter clears on beat high, else increments in RUN only; reaching WDOG_CYCLES gives verdict 11.
REQ-036 Undefined: no idle counter, code 11 never produced, beat ignored, port list unchanged.

Verification
REQ-037 Reset release, pass pulse at cycle 100, DRAIN_CYCLES=16 -> code 01 at 101, finish_req high at 117, ack at 120 -> done at 121, cycles frozen at 116.
REQ-038 ERR_MAX=8, 8 err pulses in RUN -> code 10 on 8th, DRAIN, err_cnt 8; 300 further held-high errors in DRAIN -> err_cnt 255.
REQ-039 Pass and err in same cycle, err_cnt previously 0 -> code 10, err_cnt 1.
REQ-040 Watchdog enabled, WDOG_CYCLES=50, no beat -> code 11 at cycle 50; beat every 40 cycles -> stays 00.
REQ-041 Reset low mid-REQ with finish_req high -> next cycle all outputs at reset values, state RUN.
REQ-042 Ack held high from reset onward, pass at cycle 10 -> ack ignored until REQ, done one cycle after REQ entry.

Source files
------------

// File: rtl/sim_status.sv
// Simulation verdict tracker: collects pass/error/heartbeat events, settles a verdict,
// drains, then runs a finish handshake. Optional watchdog: EXM_SIM_STATUS_WATCHDOG_EN.
module sim_status #(
  parameter int unsigned ERR_MAX      = 8,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES  = 1024
) (
  input  logic        sim_status_clk_ip,
  input  logic        sim_status_rst_n_ip,
  input  logic        sim_status_pass_ip,
  input  logic        sim_status_err_ip,
  input  logic        sim_status_beat_ip,
  input  logic        sim_status_finish_ack_ip,
  output logic        sim_status_finish_req_op,
  output logic [1:0]  sim_status_code_op,
  output logic [7:0]  sim_status_err_cnt_op,
  output logic [31:0] sim_status_cycles_op,
  output logic        sim_status_done_op
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  CODE_RUN   = 2'b00;
  localparam logic [1:0]  CODE_PASS  = 2'b01;
  localparam logic [1:0]  CODE_FAIL  = 2'b10;
  localparam logic [1:0]  CODE_WDOG  = 2'b11;
  localparam logic [7:0]  ERR_LIMIT  = 8'(ERR_MAX);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 32'd1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [1:0]  code_r, code_nxt_s;
  logic [7:0]  err_cnt_r, err_cnt_nxt_s;
  logic [31:0] cycles_r, cycles_nxt_s;
  logic [15:0] drain_cnt_r, drain_cnt_nxt_s;
  logic        finish_req_r, done_r;
  logic        err_count_en_s;
  logic        wdog_hit_s;

`ifdef EXM_SIM_STATUS_WATCHDOG_EN
  logic [31:0] idle_cnt_r, idle_cnt_nxt_s;

  // Idle counter: cleared by any heartbeat, advances only while the test is running.
  always_comb begin
    idle_cnt_nxt_s = idle_cnt_r;
    if (sim_status_beat_ip) begin
      idle_cnt_nxt_s = 32'd0;
    end else if (state_r == ST_RUN) begin
      idle_cnt_nxt_s = sat_inc32(idle_cnt_r);
    end else begin
      idle_cnt_nxt_s = idle_cnt_r;
    end
    wdog_hit_s = (state_r == ST_RUN) && (idle_cnt_nxt_s >= 32'(WDOG_CYCLES));
  end

  // Idle counter register.
  always_ff @(posedge sim_status_clk_ip) begin
    if (!sim_status_rst_n_ip) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end
`else
  logic unused_wdog_s;
  assign unused_wdog_s = sim_status_beat_ip ^ (^WDOG_CYCLES);
  assign wdog_hit_s    = 1'b0;
`endif

  // Error counting is live only before the handshake starts.
  always_comb begin
    err_count_en_s = sim_status_err_ip && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    if (err_count_en_s) begin
      err_cnt_nxt_s = sat_inc8(err_cnt_r);
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // Verdict/drain/handshake next-state logic; fail outranks pass outranks watchdog.
  always_comb begin
    state_nxt_s     = state_r;
    code_nxt_s      = code_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      ST_RUN: begin
        drain_cnt_nxt_s = 16'd0;
        if (err_cnt_nxt_s >= ERR_LIMIT) begin
          code_nxt_s  = CODE_FAIL;
          state_nxt_s = ST_DRAIN;
        end else if (sim_status_pass_ip) begin
          code_nxt_s  = (err_cnt_nxt_s == 8'd0) ? CODE_PASS : CODE_FAIL;
          state_nxt_s = ST_DRAIN;
        end else if (wdog_hit_s) begin
          code_nxt_s  = CODE_WDOG;
          state_nxt_s = ST_DRAIN;
        end else begin
          code_nxt_s  = CODE_RUN;
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // A late error still spoils a pass; a watchdog verdict is final.
        if (err_count_en_s && (code_r == CODE_PASS)) begin
          code_nxt_s = CODE_FAIL;
        end else begin
          code_nxt_s = code_r;
        end
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s     = ST_REQ;
          drain_cnt_nxt_s = 16'd0;
        end else begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = drain_cnt_r + 16'd1;
        end
      end
      ST_REQ: begin
        if (sim_status_finish_ack_ip) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s     = ST_RUN;
        code_nxt_s      = CODE_RUN;
        drain_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // Cycle counter keys off the next state so the drain-exit edge does not count.
  always_comb begin
    if ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN)) begin
      cycles_nxt_s = sat_inc32(cycles_r);
    end else begin
      cycles_nxt_s = cycles_r;
    end
  end

  // State and output registers; reset overrides every event.
  always_ff @(posedge sim_status_clk_ip) begin
    if (!sim_status_rst_n_ip) begin
      state_r      <= ST_RUN;
      code_r       <= CODE_RUN;
      err_cnt_r    <= 8'd0;
      cycles_r     <= 32'd0;
      drain_cnt_r  <= 16'd0;
      finish_req_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      code_r       <= code_nxt_s;
      err_cnt_r    <= err_cnt_nxt_s;
      cycles_r     <= cycles_nxt_s;
      drain_cnt_r  <= drain_cnt_nxt_s;
      finish_req_r <= (state_nxt_s == ST_REQ);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  assign sim_status_finish_req_op = finish_req_r;
  assign sim_status_code_op       = code_r;
  assign sim_status_err_cnt_op    = err_cnt_r;
  assign sim_status_cycles_op     = cycles_r;
  assign sim_status_done_op       = done_r;

endmodule

// File: tb/tb_sim_status.sv
// Directed bench for sim_status: dut_a uses the default drain length,
// dut_b a long drain for the error-saturation case.
module tb_sim_status;

  logic clk = 1'b0;
  logic rst_n, pass, err, beat, ack;

  logic        a_req, a_done, b_req, b_done;
  logic [1:0]  a_code, b_code;
  logic [7:0]  a_err, b_err;
  logic [31:0] a_cyc, b_cyc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_status #(.ERR_MAX(8), .DRAIN_CYCLES(16), .WDOG_CYCLES(50)) dut_a (
    .sim_status_clk_ip       (clk),
    .sim_status_rst_n_ip     (rst_n),
    .sim_status_pass_ip      (pass),
    .sim_status_err_ip       (err),
    .sim_status_beat_ip      (beat),
    .sim_status_finish_ack_ip(ack),
    .sim_status_finish_req_op(a_req),
    .sim_status_code_op      (a_code),
    .sim_status_err_cnt_op   (a_err),
    .sim_status_cycles_op    (a_cyc),
    .sim_status_done_op      (a_done)
  );

  sim_status #(.ERR_MAX(8), .DRAIN_CYCLES(400), .WDOG_CYCLES(1024)) dut_b (
    .sim_status_clk_ip       (clk),
    .sim_status_rst_n_ip     (rst_n),
    .sim_status_pass_ip      (pass),
    .sim_status_err_ip       (err),
    .sim_status_beat_ip      (beat),
    .sim_status_finish_ack_ip(ack),
    .sim_status_finish_req_op(b_req),
    .sim_status_code_op      (b_code),
    .sim_status_err_cnt_op   (b_err),
    .sim_status_cycles_op    (b_cyc),
    .sim_status_done_op      (b_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_pass();
    pass = 1'b1;
    tick(1);
    pass = 1'b0;
  endtask

  task automatic pulse_err();
    err = 1'b1;
    tick(1);
    err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pass = 1'b0; err = 1'b0; beat = 1'b1; ack = 1'b0;

    // Pass at cycle 100, drain 16, ack at 120
    do_reset();
    check_val("rst_code", {30'd0, a_code}, 32'd0);
    check_val("rst_err", {24'd0, a_err}, 32'd0);
    check_val("rst_cyc", a_cyc, 32'd0);
    check_val("rst_req", {31'd0, a_req}, 32'd0);
    check_val("rst_done", {31'd0, a_done}, 32'd0);
    tick(1);
    check_val("first_cyc", a_cyc, 32'd1);
    tick(99);
    check_val("cyc100", a_cyc, 32'd100);
    pulse_pass();
    check_val("pass_code", {30'd0, a_code}, 32'd1);
    check_val("pass_cyc", a_cyc, 32'd101);
    tick(3);
    pulse_pass();
    check_val("late_pass_code", {30'd0, a_code}, 32'd1);
    tick(11);
    check_val("drain_req116", {31'd0, a_req}, 32'd0);
    check_val("drain_cyc116", a_cyc, 32'd116);
    tick(1);
    check_val("req117", {31'd0, a_req}, 32'd1);
    check_val("freeze117", a_cyc, 32'd116);
    pulse_err();
    check_val("req_err_ignored", {24'd0, a_err}, 32'd0);
    check_val("req_code_kept", {30'd0, a_code}, 32'd1);
    tick(2);
    check_val("req_held120", {31'd0, a_req}, 32'd1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check_val("done121", {31'd0, a_done}, 32'd1);
    check_val("req_drop121", {31'd0, a_req}, 32'd0);
    check_val("freeze121", a_cyc, 32'd116);
    err = 1'b1; pass = 1'b1; ack = 1'b1;
    tick(3);
    err = 1'b0; pass = 1'b0; ack = 1'b0;
    check_val("done_term_done", {31'd0, a_done}, 32'd1);
    check_val("done_term_err", {24'd0, a_err}, 32'd0);
    check_val("done_term_code", {30'd0, a_code}, 32'd1);

    // Eight errors then saturation during a long drain, reset mid-REQ
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pulse_err();
      tick(1);
    end
    check_val("err7_cnt", {24'd0, b_err}, 32'd7);
    check_val("err7_code", {30'd0, b_code}, 32'd0);
    pulse_err();
    check_val("err8_cnt", {24'd0, b_err}, 32'd8);
    check_val("err8_code", {30'd0, b_code}, 32'd2);
    err = 1'b1;
    tick(300);
    err = 1'b0;
    check_val("err_sat", {24'd0, b_err}, 32'd255);
    check_val("sat_code", {30'd0, b_code}, 32'd2);
    check_val("sat_req", {31'd0, b_req}, 32'd0);
    tick(99);
    check_val("long_drain_end", {31'd0, b_req}, 32'd0);
    tick(1);
    check_val("long_req", {31'd0, b_req}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_val("midreq_rst_req", {31'd0, b_req}, 32'd0);
    check_val("midreq_rst_code", {30'd0, b_code}, 32'd0);
    check_val("midreq_rst_err", {24'd0, b_err}, 32'd0);
    check_val("midreq_rst_cyc", b_cyc, 32'd0);
    check_val("midreq_rst_done", {31'd0, b_done}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check_val("midreq_run_cyc", b_cyc, 32'd1);

    // Pass and error in the same cycle
    do_reset();
    tick(5);
    err = 1'b1; pass = 1'b1;
    tick(1);
    err = 1'b0; pass = 1'b0;
    check_val("pass_err_code", {30'd0, a_code}, 32'd2);
    check_val("pass_err_cnt", {24'd0, a_err}, 32'd1);

    // Error in drain demotes pass
    do_reset();
    tick(3);
    pulse_pass();
    check_val("demote_pre", {30'd0, a_code}, 32'd1);
    tick(2);
    pulse_err();
    check_val("demote_code", {30'd0, a_code}, 32'd2);
    check_val("demote_cnt", {24'd0, a_err}, 32'd1);

    // Ack held from reset, pass at cycle 10
    ack = 1'b1;
    do_reset();
    tick(10);
    check_val("ack_run_done", {31'd0, a_done}, 32'd0);
    pulse_pass();
    tick(9);
    check_val("ack_drain_done", {31'd0, a_done}, 32'd0);
    tick(6);
    check_val("ack_req26", {31'd0, a_req}, 32'd0);
    tick(1);
    check_val("ack_req27", {31'd0, a_req}, 32'd1);
    check_val("ack_done27", {31'd0, a_done}, 32'd0);
    tick(1);
    check_val("ack_done28", {31'd0, a_done}, 32'd1);
    check_val("ack_req28", {31'd0, a_req}, 32'd0);
    ack = 1'b0;

`ifdef EXM_SIM_STATUS_WATCHDOG_EN
    // Watchdog at 50 idle cycles; periodic beats keep it quiet
    beat = 1'b0;
    do_reset();
    tick(49);
    check_val("wdog49", {30'd0, a_code}, 32'd0);
    tick(1);
    check_val("wdog50", {30'd0, a_code}, 32'd3);
    check_val("wdog_cyc", a_cyc, 32'd50);
    pulse_err();
    check_val("wdog_kept", {30'd0, a_code}, 32'd3);
    check_val("wdog_err", {24'd0, a_err}, 32'd1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(39);
      beat = 1'b1;
      tick(1);
      beat = 1'b0;
    end
    check_val("beat_code", {30'd0, a_code}, 32'd0);
    check_val("beat_cyc", a_cyc, 32'd200);
`else
    // Without the watchdog a long idle run never ends
    beat = 1'b0;
    do_reset();
    tick(1100);
    check_val("idle_code", {30'd0, a_code}, 32'd0);
    check_val("idle_cyc", a_cyc, 32'd1100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
